// File: rtl/keypad_input_conditioner_if.sv
// Keypad front-end bundle: raw column lines in, conditioned column pattern,
// debounce status and the shared timebase out.
interface keypad_input_conditioner_if;
  logic [3:0]  col_raw;
  logic [3:0]  col_sync;
  logic [4:0]  debounce;
  logic        stable;
  logic        db_tick;
  logic [24:0] counter;

  modport master (
    output col_raw,
    input  col_sync, debounce, stable, db_tick, counter
  );

  modport slave (
    input  col_raw,
    output col_sync, debounce, stable, db_tick, counter
  );
endinterface

// File: rtl/keypad_input_conditioner.sv
// Keypad front end: synchronizes and normalizes the column lines, measures
// how long the pattern has been steady, and provides the shared timebase.
module keypad_input_conditioner #(
  parameter int SYNC_STAGES    = 2,
  parameter int DB_DIV         = 50000,
  parameter bit COL_ACTIVE_LOW = 1'b1
) (
  input  logic                         clk,
  input  logic                         reset,
  keypad_input_conditioner_if.slave    kp
);

  localparam int             PW     = $clog2(DB_DIV);
  localparam logic [PW-1:0]  P_LAST = PW'(DB_DIV - 1);
  localparam logic [3:0]     IDLE   = COL_ACTIVE_LOW ? 4'hF : 4'h0;
  localparam logic [4:0]     DB_MAX = 5'h1F;

  logic [SYNC_STAGES-1:0][3:0] sync_q, sync_d;
  logic [3:0]                  col_sync_q, col_sync_d;
  logic [3:0]                  col_last_q, col_last_d;
  logic [4:0]                  debounce_q, debounce_d;
  logic [PW-1:0]               prescaler_q, prescaler_d;
  logic [24:0]                 counter_q, counter_d;
  logic                        change;
  logic                        db_tick;

  always_comb begin
    sync_d     = {sync_q[SYNC_STAGES-2:0], kp.col_raw};
    col_sync_d = COL_ACTIVE_LOW ? ~sync_q[SYNC_STAGES-1] : sync_q[SYNC_STAGES-1];
    col_last_d = col_sync_q;
    counter_d  = counter_q + 25'd1;
  end

  // A pattern change restarts the step interval so a bouncing line never
  // accumulates a tick.
  always_comb begin
    change  = (col_sync_q != col_last_q);
    db_tick = (prescaler_q == P_LAST) && !change;
    if (change || (prescaler_q == P_LAST))
      prescaler_d = '0;
    else
      prescaler_d = prescaler_q + 1'b1;
  end

  always_comb begin
    debounce_d = debounce_q;
    if (col_sync_q == 4'h0)
      debounce_d = 5'd0;
    else if (change)
      debounce_d = 5'd0;
    else if (db_tick && (debounce_q != DB_MAX))
      debounce_d = debounce_q + 5'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_q      <= {SYNC_STAGES{IDLE}};
      col_sync_q  <= 4'h0;
      col_last_q  <= 4'h0;
      debounce_q  <= 5'd0;
      prescaler_q <= '0;
      counter_q   <= 25'd0;
    end else begin
      sync_q      <= sync_d;
      col_sync_q  <= col_sync_d;
      col_last_q  <= col_last_d;
      debounce_q  <= debounce_d;
      prescaler_q <= prescaler_d;
      counter_q   <= counter_d;
    end
  end

  assign kp.col_sync = col_sync_q;
  assign kp.debounce = debounce_q;
  assign kp.stable   = (debounce_q == DB_MAX);
  assign kp.db_tick  = db_tick;
  assign kp.counter  = counter_q;

endmodule

// File: tb/tb_keypad_input_conditioner.sv
// Scoreboard bench for keypad_input_conditioner (SYNC_STAGES=2, DB_DIV=4,
// active-low columns); expectations are keyed to the posedge count cyc.
module tb_keypad_input_conditioner;

  localparam logic [3:0] K1   = 4'b1110;
  localparam logic [3:0] K2   = 4'b1101;
  localparam logic [3:0] IDLE = 4'hF;
  localparam int S_COL = 0, S_DEB = 1, S_STB = 2, S_TICK = 3, S_CNT = 4;

  typedef struct {
    int cyc;
    int sel;
    int val;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb[$];
  exp_t e;
  int   act;

  keypad_input_conditioner_if kp_if ();

  keypad_input_conditioner #(
    .SYNC_STAGES(2),
    .DB_DIV(4),
    .COL_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .kp(kp_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int field(int sel);
    case (sel)
      S_COL:   return int'(kp_if.col_sync);
      S_DEB:   return int'(kp_if.debounce);
      S_STB:   return int'(kp_if.stable);
      S_TICK:  return int'(kp_if.db_tick);
      default: return int'(kp_if.counter);
    endcase
  endfunction

  function automatic string fname(int sel);
    case (sel)
      S_COL:   return "col_sync";
      S_DEB:   return "debounce";
      S_STB:   return "stable";
      S_TICK:  return "db_tick";
      default: return "counter";
    endcase
  endfunction

  task automatic exp_at(int c, int s, int v);
    exp_t x;
    int   i;
    x.cyc = c;
    x.sel = s;
    x.val = v;
    i = sb.size();
    while (i > 0 && sb[i-1].cyc > c) i--;
    sb.insert(i, x);
  endtask

  task automatic wait_to(int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: the state after posedge n is inspected at the following negedge.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e   = sb.pop_front();
      act = field(e.sel);
      n_cmp++;
      if (e.cyc != cyc || act != e.val) begin
        n_bad++;
        $display("FAIL %s @cyc %0d (seen at %0d): got %0d, want %0d",
                 fname(e.sel), e.cyc, cyc, act, e.val);
      end
    end
  end

  initial begin
    int t, r, b, p, r2, q, s;

    reset = 1'b0;
    kp_if.col_raw = IDLE;

    // Reset held for three edges, then counter runs from 0.
    exp_at(3, S_COL, 0);  exp_at(3, S_DEB, 0); exp_at(3, S_STB, 0);
    exp_at(3, S_TICK, 0); exp_at(3, S_CNT, 0);
    exp_at(4, S_CNT, 1);  exp_at(5, S_CNT, 2); exp_at(6, S_CNT, 3);
    exp_at(5, S_TICK, 0); exp_at(6, S_TICK, 1);
    wait_to(3);
    reset = 1'b1;
    $display("reset released at cyc %0d", cyc);

    // Clean press of column 1.
    t = 10;
    wait_to(t);
    exp_at(t+2, S_COL, 0);    exp_at(t+3, S_COL, 1);
    exp_at(t+4, S_DEB, 0);    exp_at(t+7, S_DEB, 0);   exp_at(t+7, S_TICK, 1);
    exp_at(t+8, S_DEB, 1);    exp_at(t+12, S_DEB, 2);  exp_at(t+124, S_DEB, 30);
    exp_at(t+127, S_STB, 0);  exp_at(t+128, S_DEB, 31); exp_at(t+128, S_STB, 1);
    exp_at(t+128, S_CNT, t+128-3);
    exp_at(t+328, S_DEB, 31); exp_at(t+328, S_STB, 1);
    kp_if.col_raw = K1;
    $display("press K1 at cyc %0d", cyc);

    // Release from saturation.
    r = t + 330;
    wait_to(r);
    exp_at(r+3, S_COL, 0); exp_at(r+3, S_DEB, 31); exp_at(r+3, S_STB, 1);
    exp_at(r+4, S_DEB, 0); exp_at(r+4, S_STB, 0);
    kp_if.col_raw = IDLE;
    $display("release at cyc %0d", cyc);

    // Bounce every 3 cycles for 300 cycles.
    b = r + 10;
    wait_to(b);
    for (int c = b + 1; c <= b + 300; c++) begin
      exp_at(c, S_DEB, 0);
      exp_at(c, S_STB, 0);
      if (c >= b + 4) exp_at(c, S_TICK, 0);
    end
    exp_at(b+3, S_COL, 1); exp_at(b+6, S_COL, 0);
    for (int k = 0; k < 100; k++) begin
      wait_to(b + 3*k);
      kp_if.col_raw = (k % 2 == 0) ? K1 : IDLE;
    end
    $display("bounce done at cyc %0d", cyc);

    // Key change at debounce=10.
    p = b + 310;
    wait_to(p);
    exp_at(p+3, S_COL, 1);   exp_at(p+4, S_DEB, 0);   exp_at(p+44, S_DEB, 10);
    exp_at(p+46, S_COL, 1);  exp_at(p+47, S_COL, 2);  exp_at(p+47, S_DEB, 10);
    exp_at(p+47, S_TICK, 0); exp_at(p+48, S_DEB, 0);  exp_at(p+171, S_DEB, 30);
    exp_at(p+172, S_DEB, 31); exp_at(p+172, S_STB, 1);
    kp_if.col_raw = K1;
    wait_to(p + 44);
    kp_if.col_raw = K2;
    $display("key change to K2 at cyc %0d", cyc);

    r2 = p + 180;
    wait_to(r2);
    exp_at(r2+2, S_COL, 2);  exp_at(r2+3, S_COL, 0);
    exp_at(r2+3, S_DEB, 31); exp_at(r2+3, S_STB, 1);
    exp_at(r2+4, S_DEB, 0);  exp_at(r2+4, S_STB, 0);
    kp_if.col_raw = IDLE;
    $display("release K2 at cyc %0d", cyc);

    // Release at debounce=20.
    q = r2 + 10;
    wait_to(q);
    exp_at(q+84, S_DEB, 20); exp_at(q+86, S_COL, 1); exp_at(q+87, S_COL, 0);
    exp_at(q+87, S_DEB, 20); exp_at(q+88, S_DEB, 0); exp_at(q+88, S_STB, 0);
    kp_if.col_raw = K1;
    wait_to(q + 84);
    kp_if.col_raw = IDLE;
    $display("release at debounce 20, cyc %0d", cyc);

    // Reset pulse at debounce=20 with the key still held.
    s = q + 95;
    wait_to(s);
    exp_at(s+84, S_DEB, 20); exp_at(s+84, S_CNT, s+84-3);
    exp_at(s+85, S_COL, 0);  exp_at(s+85, S_DEB, 0); exp_at(s+85, S_STB, 0);
    exp_at(s+85, S_TICK, 0); exp_at(s+85, S_CNT, 0);
    exp_at(s+86, S_COL, 0);  exp_at(s+86, S_DEB, 0); exp_at(s+86, S_CNT, 1);
    exp_at(s+87, S_COL, 0);  exp_at(s+87, S_CNT, 2); exp_at(s+88, S_COL, 1);
    exp_at(s+88, S_TICK, 0); exp_at(s+89, S_DEB, 0); exp_at(s+92, S_TICK, 1);
    exp_at(s+93, S_DEB, 1);  exp_at(s+93, S_CNT, 8);
    kp_if.col_raw = K1;
    wait_to(s + 84);
    reset = 1'b0;
    wait_to(s + 85);
    reset = 1'b1;
    $display("reset pulse at cyc %0d", cyc - 1);
    wait_to(s + 100);

    for (int i = 0; i < 50 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d pending, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
